// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency IF lookup, EX-side update.
// Ports: cpu_clk/cpu_rst, pc_if -> pred_taken/pred_target, upd_* -> mispredict/correct_pc;
// stat_branches/stat_mispredicts exist only when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] pc_if,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_jump,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
`ifdef BP_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  output logic        mispredict,
  output logic [31:0] correct_pc
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             unused_lsb;

  assign unused_lsb = ^{pc_if[1:0], upd_pc[1:0]};

  assign lk_idx = pc_if[IDX_W+1:2];
  assign lk_tag = pc_if[31:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit && (jump_q[lk_idx] || cnt_q[lk_idx][1]);
  assign pred_target = pred_taken ? tgt_q[lk_idx] : pc_if + 32'd4;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign mispredict = upd_valid &&
    ((upd_taken != upd_pred_taken) ||
     (upd_taken && (upd_target != upd_pred_target)));
  assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        cnt_q[i] <= CNT_INIT;
        tgt_q[i] <= '0;
      end
    end else if (upd_valid) begin
      if (upd_is_jump) begin
        valid_q[up_idx] <= 1'b1;
        jump_q[up_idx]  <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= upd_target;
        if (!up_hit)
          cnt_q[up_idx] <= 2'b10;
      end else if (up_hit) begin
        // a tag hit on a branch retypes the entry as a branch
        jump_q[up_idx] <= 1'b0;
        if (upd_taken) begin
          tgt_q[up_idx] <= upd_target;
          if (cnt_q[up_idx] != 2'b11)
            cnt_q[up_idx] <= cnt_q[up_idx] + 2'b01;
        end else if (cnt_q[up_idx] != 2'b00) begin
          cnt_q[up_idx] <= cnt_q[up_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        jump_q[up_idx]  <= 1'b0;
        tag_q[up_idx]   <= up_tag;
        cnt_q[up_idx]   <= 2'b10;
        tgt_q[up_idx]   <= upd_target;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, reset/stats sequences,
// and randomized traffic against a table-level reference model.
module tb_branch_predictor;
  localparam int ENT = 16;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] correct_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor #(.ENTRIES(ENT), .CNT_INIT(2'b01)) dut (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .pc_if(pc_if),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
`ifdef BP_STATS_EN
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts),
`endif
    .mispredict(mispredict),
    .correct_pc(correct_pc)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: one record per table slot, addressed arithmetically
  typedef struct {
    bit          v;
    bit          j;
    int          c;
    logic [31:0] tag;
    logic [31:0] tgt;
  } ent_t;
  ent_t mt[ENT];
  logic [31:0] m_br, m_mp;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction
  function automatic logic [31:0] m_tag(input logic [31:0] pc);
    return pc / (4 * ENT);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENT; i++) mt[i] = '{0, 0, 1, 0, 0};
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic m_lookup(input logic [31:0] pc, output logic tk,
                          output logic [31:0] tg);
    int i = m_idx(pc);
    bit hit = mt[i].v && mt[i].tag == m_tag(pc);
    tk = hit && (mt[i].j || mt[i].c >= 2);
    tg = tk ? mt[i].tgt : pc + 32'd4;
  endtask

  function automatic logic m_misp(input logic v, input logic tk,
      input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
    return v && (tk != ptk || (tk && tg != ptg));
  endfunction

  task automatic m_update(input logic [31:0] pc, input logic isj,
                          input logic tk, input logic [31:0] tg);
    int i = m_idx(pc);
    bit hit = mt[i].v && mt[i].tag == m_tag(pc);
    if (isj) begin
      if (!hit) mt[i].c = 2;
      mt[i].v = 1; mt[i].j = 1; mt[i].tag = m_tag(pc); mt[i].tgt = tg;
    end else if (hit) begin
      mt[i].j = 0;
      if (tk) begin
        mt[i].c = (mt[i].c < 3) ? mt[i].c + 1 : 3;
        mt[i].tgt = tg;
      end else begin
        mt[i].c = (mt[i].c > 0) ? mt[i].c - 1 : 0;
      end
    end else if (tk) begin
      mt[i] = '{1, 0, 2, m_tag(pc), tg};
    end
  endtask

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        uj;
    logic        utk;
    logic [31:0] utg;
    logic        uptk;
    logic [31:0] uptg;
    logic [31:0] pc;
    logic        e_tk;
    logic [31:0] e_tg;
    logic        e_mp;
    logic [31:0] e_cpc;
  } vec_t;
  vec_t vt[16];

  task automatic idle();
    upd_valid = 0; upd_pc = 0; upd_is_jump = 0; upd_taken = 0;
    upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
  endtask

  task automatic do_reset();
    cpu_rst = 1;
    idle();
    upd_valid = 1; upd_is_jump = 1; upd_taken = 1;
    upd_pc = 32'h300; upd_target = 32'h900;
    repeat (2) @(posedge cpu_clk);
    #1;
    cpu_rst = 0;
    idle();
    m_reset();
  endtask

  initial begin
    logic        r_tk;
    logic [31:0] r_tg;
    logic [31:0] bases [3];
    bases[0] = 32'h0;
    bases[1] = 32'h4000;
    bases[2] = 32'hFFFFFF80;

    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h104, 0, 0};
    vt[1]  = '{1, 32'h200, 0, 1, 32'h180, 0, 32'h204, 32'h200, 0, 32'h204, 1, 32'h180};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 32'h200, 1, 32'h180, 0, 0};
    vt[3]  = '{1, 32'h200, 0, 0, 32'h180, 1, 32'h180, 32'h200, 1, 32'h180, 1, 32'h204};
    vt[4]  = '{1, 32'h200, 0, 0, 32'h180, 0, 32'h204, 32'h200, 0, 32'h204, 0, 0};
    vt[5]  = '{0, 0, 0, 0, 0, 0, 0, 32'h200, 0, 32'h204, 0, 0};
    vt[6]  = '{1, 32'h40, 1, 1, 32'h400, 0, 32'h44, 32'h40, 0, 32'h44, 1, 32'h400};
    vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 32'h40, 1, 32'h400, 0, 0};
    vt[8]  = '{1, 32'h80, 0, 1, 32'h800, 0, 32'h84, 32'h40, 1, 32'h400, 1, 32'h800};
    vt[9]  = '{0, 0, 0, 0, 0, 0, 0, 32'h40, 0, 32'h44, 0, 0};
    vt[10] = '{0, 0, 0, 0, 0, 0, 0, 32'h80, 1, 32'h800, 0, 0};
    vt[11] = '{1, 32'h300, 0, 1, 32'h3F0, 0, 32'h304, 32'h300, 0, 32'h304, 1, 32'h3F0};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0, 32'h300, 1, 32'h3F0, 0, 0};
    vt[13] = '{1, 32'h300, 0, 1, 32'h3F0, 1, 32'h3F0, 32'hFFFFFFFC, 0, 32'h0, 0, 0};
    vt[14] = '{1, 32'h300, 0, 1, 32'h500, 1, 32'h3F0, 32'h300, 1, 32'h3F0, 1, 32'h500};
    vt[15] = '{0, 0, 0, 0, 0, 0, 0, 32'h300, 1, 32'h500, 0, 0};

    pc_if = 0;
    do_reset();

    foreach (vt[k]) begin
      upd_valid = vt[k].uv; upd_pc = vt[k].upc; upd_is_jump = vt[k].uj;
      upd_taken = vt[k].utk; upd_target = vt[k].utg;
      upd_pred_taken = vt[k].uptk; upd_pred_target = vt[k].uptg;
      pc_if = vt[k].pc;
      @(negedge cpu_clk);
      chk($sformatf("vec%0d pred_taken", k), {31'b0, pred_taken}, {31'b0, vt[k].e_tk});
      chk($sformatf("vec%0d pred_target", k), pred_target, vt[k].e_tg);
      chk($sformatf("vec%0d mispredict", k), {31'b0, mispredict}, {31'b0, vt[k].e_mp});
      if (vt[k].e_mp)
        chk($sformatf("vec%0d correct_pc", k), correct_pc, vt[k].e_cpc);
      @(posedge cpu_clk);
      #1;
    end
`ifdef BP_STATS_EN
    chk("tbl stat_branches", stat_branches, 32'd8);
    chk("tbl stat_mispredicts", stat_mispredicts, 32'd6);
`endif

    // reset in the middle of a populated table, with an update pending
    do_reset();
    idle();
    foreach (bases[b]) begin end
    begin
      logic [31:0] rpcs [4];
      rpcs[0] = 32'h300; rpcs[1] = 32'h40;
      rpcs[2] = 32'h80;  rpcs[3] = 32'h200;
      foreach (rpcs[k]) begin
        pc_if = rpcs[k];
        @(negedge cpu_clk);
        chk($sformatf("rst pred_taken %h", rpcs[k]), {31'b0, pred_taken}, 32'd0);
        chk($sformatf("rst pred_target %h", rpcs[k]), pred_target, rpcs[k] + 32'd4);
        @(posedge cpu_clk);
        #1;
      end
    end
`ifdef BP_STATS_EN
    chk("rst stat_branches", stat_branches, 32'd0);
    chk("rst stat_mispredicts", stat_mispredicts, 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle();
      upd_valid = 1; upd_pc = 32'h1000 + 32'(i * 4);
      upd_pred_taken = (i < 2);
      upd_pred_target = 32'h2000;
      @(posedge cpu_clk);
      #1;
    end
    idle();
    chk("seq stat_branches", stat_branches, 32'd5);
    chk("seq stat_mispredicts", stat_mispredicts, 32'd2);
`endif

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        e_mp;
      logic [31:0] e_tg;
      logic        e_tk;
      pc_if = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 31) * 4);
      upd_valid = ($urandom_range(0, 3) != 0);
      upd_pc = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 31) * 4);
      upd_is_jump = ($urandom_range(0, 4) == 0);
      upd_taken = upd_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
      upd_target = ($urandom_range(0, 1) != 0) ? 32'h8000 + 32'($urandom_range(0, 3) * 16)
                                               : $urandom;
      if ($urandom_range(0, 3) != 0) begin
        m_lookup(upd_pc, r_tk, r_tg);
        upd_pred_taken = r_tk;
        upd_pred_target = r_tg;
      end else begin
        upd_pred_taken = 1'($urandom_range(0, 1));
        upd_pred_target = upd_target;
      end
      m_lookup(pc_if, e_tk, e_tg);
      e_mp = m_misp(upd_valid, upd_taken, upd_target, upd_pred_taken, upd_pred_target);
      @(negedge cpu_clk);
      chk("rnd pred_taken", {31'b0, pred_taken}, {31'b0, e_tk});
      chk("rnd pred_target", pred_target, e_tg);
      chk("rnd mispredict", {31'b0, mispredict}, {31'b0, e_mp});
      if (e_mp)
        chk("rnd correct_pc", correct_pc, upd_taken ? upd_target : upd_pc + 32'd4);
      if (upd_valid) begin
        m_update(upd_pc, upd_is_jump, upd_taken, upd_target);
        m_br = m_br + 1;
        if (e_mp) m_mp = m_mp + 1;
      end
      @(posedge cpu_clk);
      #1;
    end
    idle();
`ifdef BP_STATS_EN
    chk("rnd stat_branches", stat_branches, m_br);
    chk("rnd stat_mispredicts", stat_mispredicts, m_mp);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
